// File: rtl/crossing_pkg.sv
// Shared definitions for the pedestrian crossing controller: FSM states,
// default phase durations and the counter preload helper.
package crossing_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WALK  = 2'd1,
    S_BLINK = 2'd2
  } cross_state_e;

  localparam int unsigned WALK_DEF  = 6;
  localparam int unsigned BLINK_DEF = 4;

  // The counter runs duration-1 .. 0, so a phase lasts exactly dur cycles.
  function automatic logic [7:0] dur_load(input int unsigned dur);
    return 8'(dur - 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit phase duration counter: load, decrement toward zero, zero flag.
module phase_timer (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (i_rst)                       cnt_q <= 8'd0;
    else if (i_load)                 cnt_q <= i_load_val;
    else if (i_dec && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
  end

  assign o_zero = (cnt_q == 8'd0);

endmodule

// File: rtl/pedestrian_crossing.sv
// Pedestrian crossing controller: starts a walk phase on the vehicle red edge
// when a request is pending, then blinks, and aborts if red is lost.
module pedestrian_crossing
  import crossing_pkg::*;
#(
  parameter int unsigned WALK  = WALK_DEF,
  parameter int unsigned BLINK = BLINK_DEF
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_red,
  input  logic i_yellow,
  input  logic i_green,
  input  logic i_button,
  output logic o_walk,
  output logic o_dont_walk,
  output logic o_req_pending,
  output logic o_abort
);

  localparam logic [7:0] WALK_LD  = dur_load(WALK);
  localparam logic [7:0] BLINK_LD = dur_load(BLINK);

  cross_state_e state_q;
  logic red_q, req_q, walk_q, dont_walk_q, abort_q;
  logic valid_red, red_edge, go;
  logic tmr_load, tmr_dec, tmr_zero;
  logic [7:0] tmr_val;

  always_comb begin
    valid_red = i_red & ~i_yellow & ~i_green;
    red_edge  = valid_red & ~red_q;
    go        = (state_q == S_IDLE) && red_edge && (req_q || i_button);
    tmr_load  = go || (state_q == S_WALK && valid_red && tmr_zero);
    tmr_val   = go ? WALK_LD : BLINK_LD;
    tmr_dec   = (state_q != S_IDLE) && valid_red;
  end

  phase_timer u_timer (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_dec      (tmr_dec),
    .o_zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      red_q       <= 1'b0;
      req_q       <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      abort_q     <= 1'b0;
    end else begin
      red_q   <= valid_red;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Starting the walk consumes the request, even if pressed again now.
          if (go) begin
            state_q     <= S_WALK;
            walk_q      <= 1'b1;
            dont_walk_q <= 1'b0;
            req_q       <= 1'b0;
          end else if (i_button) begin
            req_q <= 1'b1;
          end
        end
        S_WALK: begin
          if (!valid_red) begin
            state_q     <= S_IDLE;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            abort_q     <= 1'b1;
          end else if (tmr_zero) begin
            state_q <= S_BLINK;
            walk_q  <= 1'b1;
          end
        end
        S_BLINK: begin
          if (i_button) req_q <= 1'b1;
          if (!valid_red) begin
            state_q     <= S_IDLE;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            abort_q     <= 1'b1;
          end else if (tmr_zero) begin
            state_q     <= S_IDLE;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
          end else begin
            walk_q <= ~walk_q;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          walk_q      <= 1'b0;
          dont_walk_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_walk        = walk_q;
  assign o_dont_walk   = dont_walk_q;
  assign o_req_pending = req_q;
  assign o_abort       = abort_q;

endmodule

// File: tb/tb_pedestrian_crossing.sv
// Scenario bench for pedestrian_crossing: per-cycle stimulus and expected
// lamp vectors are queued, then applied and compared edge by edge.
module tb_pedestrian_crossing;

  logic clk = 1'b0;
  logic i_rst, i_red, i_yellow, i_green, i_button;
  logic o_walk, o_dont_walk, o_req_pending, o_abort;

  pedestrian_crossing #(.WALK(6), .BLINK(4)) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_red         (i_red),
    .i_yellow      (i_yellow),
    .i_green       (i_green),
    .i_button      (i_button),
    .o_walk        (o_walk),
    .o_dont_walk   (o_dont_walk),
    .o_req_pending (o_req_pending),
    .o_abort       (o_abort)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus {rst, red, yellow, green, button}
  localparam logic [4:0] GRN     = 5'b00010;
  localparam logic [4:0] GRN_B   = 5'b00011;
  localparam logic [4:0] YEL     = 5'b00100;
  localparam logic [4:0] RED     = 5'b01000;
  localparam logic [4:0] RED_B   = 5'b01001;
  localparam logic [4:0] RY      = 5'b01100;
  localparam logic [4:0] RG      = 5'b01010;
  localparam logic [4:0] RST_G   = 5'b10010;
  localparam logic [4:0] RST_RB  = 5'b11001;
  localparam logic [4:0] RED_RST = 5'b11000;

  // expected {walk, dont_walk, req_pending, abort}
  localparam logic [3:0] IDLE_     = 4'b0100;
  localparam logic [3:0] IDLE_P    = 4'b0110;
  localparam logic [3:0] WALK_     = 4'b1000;
  localparam logic [3:0] BLK_OFF   = 4'b0000;
  localparam logic [3:0] BLK_OFF_P = 4'b0010;
  localparam logic [3:0] BLK_ON_P  = 4'b1010;
  localparam logic [3:0] ABORT_    = 4'b0101;

  logic [4:0] stim_q[$];
  logic [3:0] sb_q[$];

  task automatic push(input logic [4:0] s, input logic [3:0] e, input int n);
    repeat (n) begin
      stim_q.push_back(s);
      sb_q.push_back(e);
    end
  endtask

  task automatic apply(input logic [4:0] s);
    {i_rst, i_red, i_yellow, i_green, i_button} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] got, exp;
    int cyc = 0;
    push(RST_G, IDLE_, 2);
    push(RST_RB, IDLE_, 1);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      exp = sb_q.pop_front();
      got = {o_walk, o_dont_walk, o_req_pending, o_abort};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b want %b", cyc, got, exp);
      end
      cyc++;
    end
  endtask

  task automatic test_normal;
    logic [3:0] got, exp;
    int cyc = 0;
    push(GRN_B, IDLE_P, 1);
    push(GRN, IDLE_P, 2);
    push(YEL, IDLE_P, 2);
    push(RED, WALK_, 7);
    push(RED, BLK_OFF, 1);
    push(RED, WALK_, 1);
    push(RED, BLK_OFF, 1);
    push(RED, IDLE_, 10);
    push(GRN, IDLE_, 2);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      exp = sb_q.pop_front();
      got = {o_walk, o_dont_walk, o_req_pending, o_abort};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL normal cyc %0d: got %b want %b", cyc, got, exp);
      end
      cyc++;
    end
  endtask

  task automatic test_no_button;
    logic [3:0] got, exp;
    int cyc = 0;
    push(GRN, IDLE_, 5);
    push(YEL, IDLE_, 2);
    push(RED, IDLE_, 6);
    push(GRN, IDLE_, 2);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      exp = sb_q.pop_front();
      got = {o_walk, o_dont_walk, o_req_pending, o_abort};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL no_button cyc %0d: got %b want %b", cyc, got, exp);
      end
      cyc++;
    end
  endtask

  task automatic test_abort;
    logic [3:0] got, exp;
    int cyc = 0;
    // drop in the third WALK cycle; button during WALK is ignored
    push(GRN_B, IDLE_P, 1);
    push(RED, WALK_, 2);
    push(RED_B, WALK_, 1);
    push(GRN, ABORT_, 1);
    push(GRN, IDLE_, 1);
    // drop exactly at WALK expiry: abort beats the move to BLINK
    push(GRN_B, IDLE_P, 1);
    push(RED, WALK_, 6);
    push(GRN, ABORT_, 1);
    push(GRN, IDLE_, 1);
    // drop during BLINK
    push(GRN_B, IDLE_P, 1);
    push(RED, WALK_, 7);
    push(RED, BLK_OFF, 1);
    push(YEL, ABORT_, 1);
    push(GRN, IDLE_, 1);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      exp = sb_q.pop_front();
      got = {o_walk, o_dont_walk, o_req_pending, o_abort};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort cyc %0d: got %b want %b", cyc, got, exp);
      end
      cyc++;
    end
  endtask

  task automatic test_button_at_edge;
    logic [3:0] got, exp;
    int cyc = 0;
    push(GRN, IDLE_, 1);
    push(RED_B, WALK_, 1);
    push(RED, WALK_, 6);
    push(RED_B, BLK_OFF_P, 1);
    push(RED, BLK_ON_P, 1);
    push(RED, BLK_OFF_P, 1);
    push(RED, IDLE_P, 4);
    push(GRN, IDLE_P, 1);
    push(RED, WALK_, 1);
    push(GRN, ABORT_, 1);
    push(GRN, IDLE_, 1);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      exp = sb_q.pop_front();
      got = {o_walk, o_dont_walk, o_req_pending, o_abort};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL button_at_edge cyc %0d: got %b want %b", cyc, got, exp);
      end
      cyc++;
    end
  endtask

  task automatic test_bad_red;
    logic [3:0] got, exp;
    int cyc = 0;
    push(GRN_B, IDLE_P, 1);
    push(RY, IDLE_P, 3);
    push(RG, IDLE_P, 1);
    push(RED, WALK_, 1);
    push(GRN, ABORT_, 1);
    push(GRN, IDLE_, 1);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      exp = sb_q.pop_front();
      got = {o_walk, o_dont_walk, o_req_pending, o_abort};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bad_red cyc %0d: got %b want %b", cyc, got, exp);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_blink;
    logic [3:0] got, exp;
    int cyc = 0;
    push(GRN_B, IDLE_P, 1);
    push(RED, WALK_, 7);
    push(RED_B, BLK_OFF_P, 1);
    push(RED_RST, IDLE_, 1);
    // red already valid at release counts as an edge
    push(RED_B, WALK_, 1);
    push(RED, WALK_, 2);
    push(RST_G, IDLE_, 1);
    push(GRN, IDLE_, 2);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      exp = sb_q.pop_front();
      got = {o_walk, o_dont_walk, o_req_pending, o_abort};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_blink cyc %0d: got %b want %b", cyc, got, exp);
      end
      cyc++;
    end
  endtask

  initial begin
    {i_rst, i_red, i_yellow, i_green, i_button} = RST_G;
    test_reset();
    test_normal();
    test_no_button();
    test_abort();
    test_button_at_edge();
    test_bad_red();
    test_reset_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pedestrian_crossing.md
PEDESTRIAN_CROSSING -- requirements
Module: pedestrian_crossing

Interface
REQ-001 Parameter WALK, default 6, steady-walk duration in clock cycles (legal range 1..255).
REQ-002 Parameter BLINK, default 4, blinking-walk duration in clock cycles (legal range 1..255).
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port i_rst, input, 1, reset, synchronous, active-high.
REQ-005 Port i_red, input, 1, vehicle red lamp from the upstream traffic_light stage.
REQ-006 Port i_yellow, input, 1, vehicle yellow lamp from traffic_light.
REQ-007 Port i_green, input, 1, vehicle green lamp from traffic_light.
REQ-008 Port i_button, input, 1, pedestrian request, level, already synchronised.
REQ-009 Port o_walk, output, 1, walk lamp.
REQ-010 Port o_dont_walk, output, 1, don't-walk lamp.
REQ-011 Port o_req_pending, output, 1, request latched, not yet served.
REQ-012 Port o_abort, output, 1, one-cycle pulse when a walk phase is cut short.

Function
REQ-013 Valid red = i_red & ~i_yellow & ~i_green; any other lamp combination is treated as not-red.
REQ-014 Red edge = valid red this cycle and not valid red in the previous cycle (registered red_q).
REQ-015 States: IDLE, WALK, BLINK; all outputs registered.
REQ-016 IDLE outputs: o_dont_walk=1, o_walk=0.
REQ-017 IDLE->WALK on a red edge when o_req_pending=1 or i_button=1 in that cycle; otherwise stay in IDLE.
REQ-018 WALK outputs: o_walk=1, o_dont_walk=0, for exactly WALK cycles, then ->BLINK.
REQ-019 BLINK outputs: o_dont_walk=0, o_walk=1 in the first BLINK cycle, toggling every cycle, for exactly BLINK cycles, then ->IDLE.
REQ-020 Valid red low in any WALK or BLINK cycle: ->IDLE at the next edge, o_abort=1 for that single IDLE cycle.
REQ-021 Abort takes priority over normal WALK/BLINK expiry in the same cycle.
REQ-022 o_req_pending is set by i_button=1 in IDLE or BLINK, ignored in WALK, and cleared on the IDLE->WALK transition.
REQ-023 Clear wins over set when i_button=1 coincides with the IDLE->WALK transition.
REQ-024 A request whose red edge is missed waits for the next red edge; no walk starts mid-red.
REQ-025 Phase counter is 8 bits, loaded with duration-1 on state entry, decremented to 0, no wrap.
REQ-026 o_walk and o_dont_walk are never both 1; o_dont_walk=0 only in WALK/BLINK.

Reset
REQ-027 While i_rst=1 at an edge: state=IDLE, o_dont_walk=1, o_walk=0, o_req_pending=0, o_abort=0, red_q=0, counter=0.
REQ-028 Reset mid-WALK/BLINK returns to IDLE at the next edge with the pending request discarded and no o_abort pulse.
REQ-029 The first cycle after reset release with red already valid counts as a red edge (red_q=0).

Structure
REQ-030 State encoding and the WALK/BLINK defaults are defined in shared package crossing_pkg.
REQ-031 The duration counter is sub-module phase_timer (load, decrement, zero flag).
REQ-032 The top level contains only the red-edge register, request latch, FSM and output registers.

Verification
REQ-033 Button pulse in green, then red held for 20 cycles -> o_req_pending=1 until the red edge; o_walk high 6 cycles, then pattern 1,0,1,0, then o_dont_walk=1.
REQ-034 No button over a full light cycle -> o_dont_walk=1 and o_walk=0 throughout.
REQ-035 Red drops 3 cycles into WALK -> IDLE the next cycle, o_abort pulse 1 cycle, o_walk=0.
REQ-036 Button pressed in the red-edge cycle -> walk starts; o_req_pending stays 0.
REQ-037 i_red=1 and i_yellow=1 together with a pending request -> no walk starts; request remains pending.
REQ-038 i_rst=1 during BLINK -> next cycle o_dont_walk=1, o_req_pending=0, o_abort=0.
